// File: rtl/uart_apb_regif.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_apb_regif : APB3 register front end and strobe generator for CoreUART  |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module uart_apb_regif #(
  parameter bit          FIXEDMODE      = 1'b0,
  parameter logic [12:0] BAUD_VALUE     = 13'd1,
  parameter logic [2:0]  BAUD_FRACTION  = 3'd0,
  parameter bit          BIT8_DEF       = 1'b1,
  parameter bit          PARITY_EN_DEF  = 1'b0,
  parameter bit          ODD_N_EVEN_DEF = 1'b0
) (
  input  logic        CLK,
  input  logic        aresetn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [4:0]  PADDR,
  input  logic [7:0]  PWDATA,
  output logic [7:0]  PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        UART_CSN,
  output logic        UART_WEN,
  output logic        UART_OEN,
  output logic [7:0]  UART_DATA_IN,
  input  logic [7:0]  UART_DATA_OUT,
  output logic [12:0] BAUD_VAL,
  output logic [2:0]  BAUD_VAL_FRACTION,
  output logic        BIT8,
  output logic        PARITY_EN,
  output logic        ODD_N_EVEN,
  input  logic        TXRDY,
  input  logic        RXRDY,
  input  logic        PARITY_ERR,
  input  logic        OVERFLOW,
  input  logic        FRAMING_ERR,
  output logic        IRQ
);

  localparam logic [2:0] c_A_TXDATA   = 3'd0;
  localparam logic [2:0] c_A_RXDATA   = 3'd1;
  localparam logic [2:0] c_A_CTRL1    = 3'd2;
  localparam logic [2:0] c_A_CTRL2    = 3'd3;
  localparam logic [2:0] c_A_STATUS   = 3'd4;
  localparam logic [2:0] c_A_IRQ_EN   = 3'd5;
  localparam logic [2:0] c_A_IRQ_STAT = 3'd6;
  localparam logic [2:0] c_A_CTRL3    = 3'd7;

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_RD_CAP = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
  logic [7:0]  rd_hold_q, txd_q;
  logic [12:0] baud_q;
  logic [2:0]  frac_q;
  logic        bit8_q, par_q, odd_q;
  logic [4:0]  irq_en_q, irq_stat_q, irq_stat_d, stat_prev_q;
  logic        irq_q;

  logic [2:0]  w_sel;
  logic        w_idle, w_access, w_wr, w_rd, w_rx_rd, w_wr_err, w_wr_ok, w_tx_wr;
  logic [4:0]  w_stat_in, w_w1c;
  logic [7:0]  w_rdata;
  logic        w_unused;

  assign w_sel    = PADDR[4:2];
  assign w_unused = &{1'b0, PADDR[1:0]};
  assign w_idle   = (state_q == c_IDLE);
  assign w_access = PSEL & PENABLE;
  // Side effects only in IDLE: an access seen in RD_CAP is the completing RX read.
  assign w_wr     = w_access &  PWRITE & w_idle;
  assign w_rd     = w_access & ~PWRITE & w_idle;
  assign w_rx_rd  = w_rd & (w_sel == c_A_RXDATA);
  assign w_wr_err = w_wr & ((w_sel == c_A_RXDATA) | (w_sel == c_A_STATUS) |
                            (FIXEDMODE & ((w_sel == c_A_CTRL1) | (w_sel == c_A_CTRL2) |
                                          (w_sel == c_A_CTRL3))));
  assign w_wr_ok  = w_wr & ~w_wr_err;
  assign w_tx_wr  = w_wr_ok & (w_sel == c_A_TXDATA);

  assign w_stat_in = {FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY};
  assign w_w1c     = (w_wr_ok && (w_sel == c_A_IRQ_STAT)) ? PWDATA[4:0] : 5'd0;
  assign irq_stat_d = (irq_stat_q & ~w_w1c) | (w_stat_in & ~stat_prev_q);

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) state_q <= c_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:   if (w_rx_rd) state_d = c_RD_CAP;
      c_RD_CAP: state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  always_comb begin
    PREADY  = ~w_rx_rd;
    PSLVERR = w_wr_err | (w_rd & (w_sel == c_A_TXDATA));
    csn_d   = 1'b1;
    wen_d   = 1'b1;
    oen_d   = 1'b1;
    if (w_rx_rd) begin
      csn_d = 1'b0;
      oen_d = 1'b0;
    end
    if (w_tx_wr) begin
      csn_d = 1'b0;
      wen_d = 1'b0;
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    case (w_sel)
      c_A_CTRL1:    w_rdata = baud_q[7:0];
      c_A_CTRL2:    w_rdata = {baud_q[12:8], odd_q, par_q, bit8_q};
      c_A_STATUS:   w_rdata = {3'b000, w_stat_in};
      c_A_IRQ_EN:   w_rdata = {3'b000, irq_en_q};
      c_A_IRQ_STAT: w_rdata = {3'b000, irq_stat_q};
      c_A_CTRL3:    w_rdata = {5'b00000, frac_q};
      default:      w_rdata = 8'h00;
    endcase
  end

  // RX data holds on the bus from RD_CAP until another register read replaces it.
  assign PRDATA = (w_rd && (w_sel != c_A_RXDATA)) ? w_rdata : rd_hold_q;

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      csn_q       <= 1'b1;
      wen_q       <= 1'b1;
      oen_q       <= 1'b1;
      rd_hold_q   <= 8'h00;
      txd_q       <= 8'h00;
      baud_q      <= BAUD_VALUE;
      frac_q      <= BAUD_FRACTION;
      bit8_q      <= BIT8_DEF;
      par_q       <= PARITY_EN_DEF;
      odd_q       <= ODD_N_EVEN_DEF;
      irq_en_q    <= 5'd0;
      irq_stat_q  <= 5'd0;
      stat_prev_q <= 5'd0;
      irq_q       <= 1'b0;
    end else begin
      csn_q       <= csn_d;
      wen_q       <= wen_d;
      oen_q       <= oen_d;
      stat_prev_q <= w_stat_in;
      irq_stat_q  <= irq_stat_d;
      irq_q       <= |(irq_stat_q & irq_en_q);
      if (w_rx_rd) rd_hold_q <= UART_DATA_OUT;
      if (w_tx_wr) txd_q <= PWDATA;
      if (w_wr_ok) begin
        case (w_sel)
          c_A_CTRL1:  baud_q[7:0] <= PWDATA;
          c_A_CTRL2: begin
            baud_q[12:8] <= PWDATA[7:3];
            odd_q        <= PWDATA[2];
            par_q        <= PWDATA[1];
            bit8_q       <= PWDATA[0];
          end
          c_A_IRQ_EN: irq_en_q <= PWDATA[4:0];
          c_A_CTRL3:  frac_q   <= PWDATA[2:0];
          default: ;
        endcase
      end
    end
  end

  assign UART_CSN          = csn_q;
  assign UART_WEN          = wen_q;
  assign UART_OEN          = oen_q;
  assign UART_DATA_IN      = txd_q;
  assign BAUD_VAL          = baud_q;
  assign BAUD_VAL_FRACTION = frac_q;
  assign BIT8              = bit8_q;
  assign PARITY_EN         = par_q;
  assign ODD_N_EVEN        = odd_q;
  assign IRQ               = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_regif.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_uart_apb_regif : directed vector bench for uart_apb_regif                |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module tb_uart_apb_regif;

  logic CLK = 1'b0;
  logic aresetn = 1'b0;
  always #5 CLK = ~CLK;

  logic psel_a = 1'b0, psel_f = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0] paddr = 5'd0;
  logic [7:0] pwdata = 8'd0;
  logic st_tx = 1'b0, st_rx = 1'b0, st_pe = 1'b0, st_ov = 1'b0, st_fe = 1'b0;
  logic [7:0] rx_a = 8'h00, rx_f = 8'h00, rx_val = 8'h00;
  logic rx_set = 1'b0;

  logic [7:0] prdata_a, prdata_f, din_a, din_f;
  logic pready_a, pready_f, pslverr_a, pslverr_f;
  logic csn_a, wen_a, oen_a, csn_f, wen_f, oen_f;
  logic [12:0] baud_a, baud_f;
  logic [2:0] frac_a, frac_f;
  logic bit8_a, par_a, odd_a, irq_a, bit8_f, par_f, odd_f, irq_f;

  uart_apb_regif u_dut (
    .CLK(CLK), .aresetn(aresetn), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a),
    .UART_CSN(csn_a), .UART_WEN(wen_a), .UART_OEN(oen_a), .UART_DATA_IN(din_a),
    .UART_DATA_OUT(rx_a), .BAUD_VAL(baud_a), .BAUD_VAL_FRACTION(frac_a), .BIT8(bit8_a),
    .PARITY_EN(par_a), .ODD_N_EVEN(odd_a), .TXRDY(st_tx), .RXRDY(st_rx),
    .PARITY_ERR(st_pe), .OVERFLOW(st_ov), .FRAMING_ERR(st_fe), .IRQ(irq_a));

  uart_apb_regif #(.FIXEDMODE(1'b1)) u_fix (
    .CLK(CLK), .aresetn(aresetn), .PSEL(psel_f), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_f), .PREADY(pready_f), .PSLVERR(pslverr_f),
    .UART_CSN(csn_f), .UART_WEN(wen_f), .UART_OEN(oen_f), .UART_DATA_IN(din_f),
    .UART_DATA_OUT(rx_f), .BAUD_VAL(baud_f), .BAUD_VAL_FRACTION(frac_f), .BIT8(bit8_f),
    .PARITY_EN(par_f), .ODD_N_EVEN(odd_f), .TXRDY(st_tx), .RXRDY(st_rx),
    .PARITY_ERR(st_pe), .OVERFLOW(st_ov), .FRAMING_ERR(st_fe), .IRQ(irq_f));

  // Core model: RX byte is consumed (cleared) by the OEN strobe.
  always @(posedge CLK) begin
    if (rx_set)      rx_a <= rx_val;
    else if (!oen_a) rx_a <= 8'h00;
  end

  int viol = 0, n_wen = 0, n_oen = 0, n_oen_rdy = 0;
  logic prev_low = 1'b0;
  always @(negedge CLK) begin
    if (!wen_a && !oen_a) viol++;
    if (csn_a != (wen_a & oen_a)) viol++;
    if (!csn_a && prev_low) viol++;
    prev_low = !csn_a;
    if (!wen_a) n_wen++;
    if (!oen_a) n_oen++;
    if (!oen_a && pready_a) n_oen_rdy++;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apb(input bit fix, input bit wr, input logic [4:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic err, output int waits);
    @(posedge CLK); #1;
    psel_a = !fix; psel_f = fix; pwrite = wr; paddr = addr; pwdata = wd; penable = 1'b0;
    @(posedge CLK); #1;
    penable = 1'b1;
    waits = 0;
    #3;
    while (!(fix ? pready_f : pready_a) && waits < 8) begin
      @(posedge CLK); #4;
      waits++;
    end
    rd  = fix ? prdata_f : prdata_a;
    err = fix ? pslverr_f : pslverr_a;
    @(posedge CLK); #1;
    psel_a = 1'b0; psel_f = 1'b0; penable = 1'b0;
  endtask

  task automatic set_rx(input logic [7:0] v);
    @(posedge CLK); #1 rx_val = v; rx_set = 1'b1;
    @(posedge CLK); #1 rx_set = 1'b0;
  endtask

  typedef struct {
    bit         wr;
    logic [4:0] addr;
    logic [7:0] wd;
    logic [7:0] exp;
    bit         err;
  } vec_t;

  vec_t tbl[19];
  logic [7:0] rd;
  logic err;
  int w, base;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 5'h08, 8'h00, 8'h01, 1'b0};
    tbl[1]  = '{1'b0, 5'h0C, 8'h00, 8'h01, 1'b0};
    tbl[2]  = '{1'b0, 5'h14, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 5'h18, 8'h00, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 5'h10, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 5'h1C, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 5'h00, 8'h00, 8'h00, 1'b1};
    tbl[7]  = '{1'b1, 5'h04, 8'h55, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 5'h10, 8'h55, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 5'h08, 8'h34, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 5'h0C, 8'hAE, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 5'h08, 8'h00, 8'h34, 1'b0};
    tbl[12] = '{1'b0, 5'h0C, 8'h00, 8'hAE, 1'b0};
    tbl[13] = '{1'b1, 5'h1C, 8'hFD, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 5'h1C, 8'h00, 8'h05, 1'b0};
    tbl[15] = '{1'b1, 5'h14, 8'hFF, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 5'h14, 8'h00, 8'h1F, 1'b0};
    tbl[17] = '{1'b1, 5'h14, 8'h02, 8'h00, 1'b0};
    tbl[18] = '{1'b0, 5'h14, 8'h00, 8'h02, 1'b0};

    repeat (3) @(posedge CLK);
    #1 aresetn = 1'b1;
    @(posedge CLK); #1;
    check("rst_csn", csn_a, 1'b1);
    check("rst_wen", wen_a, 1'b1);
    check("rst_oen", oen_a, 1'b1);
    check("rst_irq", irq_a, 1'b0);
    check("rst_baud", baud_a, 13'd1);
    check("rst_prdata", prdata_a, 8'h00);
    check("rst_din", din_a, 8'h00);
    check("rst_line", {bit8_a, par_a, odd_a, frac_a}, 6'b100_000);

    for (int i = 0; i < 19; i++) begin
      apb(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, err, w);
      check($sformatf("vec%0d_err", i), err, tbl[i].err);
      check($sformatf("vec%0d_wait", i), w, 0);
      if (!tbl[i].wr) check($sformatf("vec%0d_rd", i), rd, tbl[i].exp);
    end
    check("cfg_baud", baud_a, 13'h1534);
    check("cfg_line", {bit8_a, par_a, odd_a, frac_a}, 6'b011_101);

    // TX write: strobe in the cycle after the access, exactly one cycle wide
    base = n_wen;
    apb(1'b0, 1'b1, 5'h00, 8'hA5, rd, err, w);
    check("tx_err", err, 1'b0);
    check("tx_wait", w, 0);
    check("tx_din", din_a, 8'hA5);
    check("tx_strobe_low", {csn_a, wen_a, oen_a}, 3'b001);
    @(posedge CLK); #1;
    check("tx_strobe_high", {csn_a, wen_a, oen_a}, 3'b111);
    check("tx_wen_pulses", n_wen - base, 1);

    // RX read: one wait state, data captured before the core clears it
    set_rx(8'h3C);
    base = n_oen;
    w = n_oen_rdy;
    apb(1'b0, 1'b0, 5'h04, 8'h00, rd, err, w);
    check("rx_wait", w, 1);
    check("rx_data", rd, 8'h3C);
    check("rx_err", err, 1'b0);
    check("rx_oen_pulses", n_oen - base, 1);
    check("rx_core_cleared", rx_a, 8'h00);
    @(posedge CLK); #1;
    check("rx_prdata_hold", prdata_a, 8'h3C);
    check("rx_oen_with_ready", n_oen_rdy, 1);

    // IRQ: RXRDY edge sets IRQ_STAT, IRQ follows a cycle later
    @(posedge CLK); #1 st_rx = 1'b1;
    @(posedge CLK); #1;
    check("irq_lag", irq_a, 1'b0);
    @(posedge CLK); #1;
    check("irq_set", irq_a, 1'b1);
    apb(1'b0, 1'b0, 5'h18, 8'h00, rd, err, w);
    check("irqstat_rx", rd, 8'h02);
    st_rx = 1'b0;
    repeat (2) @(posedge CLK);
    #1 psel_a = 1'b1; pwrite = 1'b1; paddr = 5'h18; pwdata = 8'h02; penable = 1'b0;
    @(posedge CLK); #1 penable = 1'b1; st_rx = 1'b1;
    @(posedge CLK); #1 psel_a = 1'b0; penable = 1'b0;
    apb(1'b0, 1'b0, 5'h18, 8'h00, rd, err, w);
    check("irq_set_wins", rd, 8'h02);
    check("irq_still_set", irq_a, 1'b1);
    apb(1'b0, 1'b1, 5'h18, 8'h02, rd, err, w);
    check("w1c_err", err, 1'b0);
    apb(1'b0, 1'b0, 5'h18, 8'h00, rd, err, w);
    check("w1c_cleared", rd, 8'h00);
    check("irq_cleared", irq_a, 1'b0);
    @(posedge CLK); #1 st_tx = 1'b1;
    apb(1'b0, 1'b0, 5'h18, 8'h00, rd, err, w);
    check("irqstat_tx_masked", rd, 8'h01);
    apb(1'b0, 1'b0, 5'h10, 8'h00, rd, err, w);
    check("status_rd", rd, 8'h03);
    check("irq_masked", irq_a, 1'b0);

    // Fixed-mode instance rejects configuration writes
    apb(1'b1, 1'b1, 5'h0C, 8'hFF, rd, err, w);
    check("fix_ctrl2_err", err, 1'b1);
    apb(1'b1, 1'b0, 5'h0C, 8'h00, rd, err, w);
    check("fix_ctrl2_rd", rd, 8'h01);
    apb(1'b1, 1'b1, 5'h10, 8'h12, rd, err, w);
    check("fix_status_err", err, 1'b1);
    apb(1'b1, 1'b1, 5'h08, 8'h77, rd, err, w);
    check("fix_ctrl1_err", err, 1'b1);
    check("fix_outputs", {baud_f, bit8_f, par_f, odd_f}, {13'd1, 3'b100});

    // Reset asserted in the RD_CAP cycle
    set_rx(8'h5A);
    @(posedge CLK); #1 psel_a = 1'b1; pwrite = 1'b0; paddr = 5'h04; penable = 1'b0;
    @(posedge CLK); #1 penable = 1'b1;
    @(posedge CLK); #2;
    check("rdcap_strobe", {csn_a, oen_a}, 2'b00);
    aresetn = 1'b0;
    #1;
    check("async_strobes", {csn_a, wen_a, oen_a}, 3'b111);
    psel_a = 1'b0; penable = 1'b0;
    @(posedge CLK); #1 aresetn = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_strobes", {csn_a, wen_a, oen_a}, 3'b111);
    check("post_rst_baud", baud_a, 13'd1);
    apb(1'b0, 1'b0, 5'h18, 8'h00, rd, err, w);
    check("post_rst_irqstat", rd, 8'h03);
    set_rx(8'h77);
    base = n_oen;
    apb(1'b0, 1'b0, 5'h04, 8'h00, rd, err, w);
    check("rx2_wait", w, 1);
    check("rx2_data", rd, 8'h77);
    check("rx2_oen_pulses", n_oen - base, 1);

    repeat (2) @(posedge CLK);
    check("strobe_rules", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_apb_regif.md
# uart_apb_regif

APB3 slave register interface that sits directly upstream of the CoreUART core and converts APB transfers into its single-cycle active-low CSN/WEN/OEN strobes. It also owns the runtime configuration (baud value and fraction, data width, parity) and latches the core's status flags into a maskable, edge-triggered interrupt. The APB read path returns RX data only after capturing it ahead of the core's read side effect.

## Interface
- FIXEDMODE, 0: 1 = CTRL registers read-only, outputs tied to parameter defaults.
- BAUD_VALUE, 1: reset value of BAUD_VAL[12:0].
- BAUD_FRACTION, 0: reset value of BAUD_VAL_FRACTION[2:0].
- BIT8_DEF, 1; PARITY_EN_DEF, 0; ODD_N_EVEN_DEF, 0: reset values of the line-format outputs.

Ports:
- CLK  in  1  system clock; CoreUART runs on the same clock.
- aresetn  in  1  reset, asynchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
- PADDR  in  5  byte address; PADDR[4:2] selects the register.
- PWDATA  in  8; PRDATA  out  8; PREADY  out  1; PSLVERR  out  1.
- UART_CSN, UART_WEN, UART_OEN  out  1 each  active-low strobes to the core.
- UART_DATA_IN  out  8  TX byte to the core.
- UART_DATA_OUT  in  8  RX byte from the core.
- BAUD_VAL  out  13; BAUD_VAL_FRACTION  out  3; BIT8, PARITY_EN, ODD_N_EVEN  out  1 each.
- TXRDY, RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR  in  1 each  core status.
- IRQ  out  1  registered interrupt, active-high.

## Operation
- Register map (word offsets):
  - 0x00 TXDATA: W.
  - 0x04 RXDATA: R.
  - 0x08 CTRL1: BAUD_VAL[7:0].
  - 0x0C CTRL2: [7:3] BAUD_VAL[12:8]; [2] ODD_N_EVEN; [1] PARITY_EN; [0] BIT8.
  - 0x10 STATUS: R; {3'b0, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY}.
  - 0x14 IRQ_EN: RW [4:0].
  - 0x18 IRQ_STAT: R, W1C [4:0].
  - 0x1C CTRL3: BAUD_VAL_FRACTION in [2:0].
- Unused read bits return 0.
- TXDATA write: UART_DATA_IN <= PWDATA. A one-cycle UART_CSN=0, UART_WEN=0 pulse follows the accepting access cycle.
- RXDATA read: state machine IDLE -> RD_CAP -> IDLE.
  - IDLE on RXDATA read access: PREADY=0; UART_DATA_OUT is latched into rd_hold at the clock edge; moves to RD_CAP.
  - RD_CAP: PREADY=1 and PRDATA=rd_hold; UART_CSN=0, UART_OEN=0 for exactly this cycle; returns to IDLE.
- All other accesses complete with zero wait states (PREADY=1 in the first access cycle).
- UART_CSN/WEN/OEN are registered outputs. They are never low for more than one cycle and are never low simultaneously for WEN and OEN.
- PSLVERR=1, with no side effect, on:
  - a write to RXDATA or STATUS;
  - a write to CTRL1/2/3 when FIXEDMODE=1;
  - a read of TXDATA (which returns 0).
- IRQ_STAT[4:0] maps to {FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY}.
  - A bit sets on the 0->1 edge of its input, detected against a registered copy of the previous value.
  - Writing 1 clears a bit. Set wins over a same-cycle W1C.
- IRQ <= |(IRQ_STAT & IRQ_EN), one cycle after the contributing state.

## Timing
- Reset values:
  - UART_CSN, UART_WEN, UART_OEN = 1.
  - UART_DATA_IN = 0; PRDATA = 0; IRQ = 0; IRQ_STAT = 0; IRQ_EN = 0.
  - Config outputs = parameter defaults; state = IDLE.
  - Edge-detect registers reset to 0, so inputs already high after reset set their IRQ_STAT bits on the first clock.
- Write latency:
  - Configuration outputs update on the clock edge ending the access cycle.
  - The TX strobe is active in the following cycle.
- RXDATA read takes 3 APB cycles (setup, wait, access). PRDATA is stable from the RD_CAP cycle until the next transfer.
- PRDATA for other registers is driven combinationally in the access cycle.
- Back-to-back transfers: the APB setup phase guarantees one idle strobe cycle between consecutive core strobes.
- PSEL or PENABLE dropping in RD_CAP (protocol violation): the strobe still completes and the FSM returns to IDLE.
- aresetn asserted mid-transfer: strobes return to 1 immediately (async), the FSM goes to IDLE, and there is no partial strobe on release.

## Test plan
- Reset, then read CTRL1/CTRL2 -> 0x01 / 0x01 with defaults; BAUD_VAL=1, IRQ=0, all strobes high.
- Write 0xA5 to TXDATA -> UART_DATA_IN=0xA5; UART_CSN/WEN low for exactly one cycle after the access; PREADY=1 with no wait.
- Model drives UART_DATA_OUT=0x3C and changes it to 0x00 on the OEN pulse; read RXDATA -> PREADY low for 1 cycle, PRDATA=0x3C, single OEN/CSN pulse coincident with PREADY=1.
- IRQ_EN=0x02, RXRDY rises -> IRQ_STAT=0x02 and IRQ=1 one cycle later. Write 0x02 to IRQ_STAT in the same cycle as a second RXRDY edge -> the bit stays set.
- FIXEDMODE=1: write 0xFF to CTRL2 -> PSLVERR=1 and CTRL2 unchanged; write to STATUS -> PSLVERR=1.
- Assert aresetn during the RD_CAP cycle -> strobes return to 1 asynchronously; the next RXDATA read behaves normally.
